// File: rtl/adc_capture_tohost_pkg.sv
// adc_capture_tohost_pkg: shared state encoding and default widths for the ADC capture engine.
package adc_capture_tohost_pkg;
    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;
    localparam int DEF_DATAWIDTH = 64;
    localparam int DEF_ADDRWIDTH = 13;
    localparam int DEF_DECWIDTH  = 8;
endpackage

// File: rtl/adc_capture_tohost_capture_decimator.sv
// capture_decimator: divide-by-(decim+1) sample strobe; load holds the phase at 0.
module capture_decimator
    import adc_capture_tohost_pkg::*;
#(
    parameter int DECWIDTH = DEF_DECWIDTH
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_load,
    input  logic [DECWIDTH-1:0] i_decim,
    output logic                o_strobe
);
    logic [DECWIDTH-1:0] r_cnt;
    always_ff @(posedge i_clk) begin
        if (i_reset || i_load) r_cnt <= '0;
        else r_cnt <= (r_cnt == i_decim) ? '0 : r_cnt + 1'b1;
    end
    assign o_strobe = r_cnt == '0;
endmodule

// File: rtl/adc_capture_tohost.sv
// adc_capture_tohost: armed/triggered ADC snapshot into the to-host BRAM write port.
// Optional decimation is built only when ADC_CAPTURE_DECIM_EN is defined.
module adc_capture_tohost
    import adc_capture_tohost_pkg::*;
#(
    parameter int DATAWIDTH = DEF_DATAWIDTH,
    parameter int ADDRWIDTH = DEF_ADDRWIDTH,
    parameter int DECWIDTH  = DEF_DECWIDTH
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [DATAWIDTH-1:0] i_adc,
    input  logic                 i_start,
    input  logic                 i_trig,
    input  logic [ADDRWIDTH-1:0] i_lastaddr,
    input  logic [DECWIDTH-1:0]  i_decim,
    output logic [ADDRWIDTH-1:0] o_bram_addr,
    output logic [DATAWIDTH-1:0] o_bram_data,
    output logic                 o_bram_we,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [ADDRWIDTH:0]   o_wordcount
);
    state_t r_state, w_next;
    logic [ADDRWIDTH-1:0] r_lastaddr, r_ptr;
    logic [DATAWIDTH-1:0] r_adc;
    logic r_prime;
    logic w_tick, w_wr, w_last, w_arm, w_trig;

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_arm  = 1'b0;
        w_trig = 1'b0;
        w_wr   = 1'b0;
        case (r_state)
            IDLE, DONE: if (i_start) begin
                w_next = ARMED;
                w_arm  = 1'b1;
            end
            ARMED: if (i_trig) begin
                w_next = CAPTURE;
                w_trig = 1'b1;
            end
            CAPTURE: begin
                w_wr = !r_prime && w_tick;
                if (w_wr && w_last) w_next = DONE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_last = r_ptr == r_lastaddr;
    assign o_busy = (r_state == ARMED) || (r_state == CAPTURE);

    // r_prime skips the first CAPTURE cycle so the first word is the sample after the trigger edge
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_lastaddr  <= '0;
            r_ptr       <= '0;
            r_prime     <= 1'b0;
            r_adc       <= '0;
            o_bram_addr <= '0;
            o_bram_data <= '0;
            o_bram_we   <= 1'b0;
            o_done      <= 1'b0;
            o_wordcount <= '0;
        end else begin
            r_adc     <= i_adc;
            r_prime   <= w_trig;
            o_bram_we <= w_wr;
            if (w_arm) begin
                r_lastaddr  <= i_lastaddr;
                o_done      <= 1'b0;
                o_wordcount <= '0;
            end
            if (w_trig) r_ptr <= '0;
            if (w_wr) begin
                o_bram_addr <= r_ptr;
                o_bram_data <= r_adc;
                r_ptr       <= r_ptr + 1'b1;
                o_wordcount <= o_wordcount + 1'b1;
                o_done      <= w_last;
            end
        end
    end

`ifdef ADC_CAPTURE_DECIM_EN
    logic [DECWIDTH-1:0] r_decim;
    always_ff @(posedge i_clk) begin
        if (i_reset) r_decim <= '0;
        else if (w_arm) r_decim <= i_decim;
    end
    capture_decimator #(.DECWIDTH(DECWIDTH)) u_decim (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_load   ((r_state != CAPTURE) || r_prime),
        .i_decim  (r_decim),
        .o_strobe (w_tick)
    );
`else
    logic w_unused;
    assign w_tick   = 1'b1;
    assign w_unused = ^i_decim;
`endif
endmodule

// File: tb/tb_adc_capture_tohost.sv
// tb_adc_capture_tohost: directed checks of arming, triggering, capture length, wrap and reset.
module tb_adc_capture_tohost;
    localparam int DW = 16;
    localparam int AW = 4;
    localparam int CW = 8;
`ifdef ADC_CAPTURE_DECIM_EN
    localparam int DSP = 3;
`else
    localparam int DSP = 1;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [DW-1:0] adc = 16'h1000;
    logic start = 1'b0;
    logic trig = 1'b0;
    logic [AW-1:0] lastaddr = '0;
    logic [CW-1:0] decim = '0;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_data;
    logic bram_we, busy, done;
    logic [AW:0] wordcount;
    int total = 0;
    int bad = 0;
    logic [DW-1:0] d0;

    adc_capture_tohost #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .DECWIDTH(CW)) dut (
        .i_clk(clk), .i_reset(reset), .i_adc(adc), .i_start(start), .i_trig(trig),
        .i_lastaddr(lastaddr), .i_decim(decim), .o_bram_addr(bram_addr),
        .o_bram_data(bram_data), .o_bram_we(bram_we), .o_busy(busy), .o_done(done),
        .o_wordcount(wordcount)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        adc = adc + 1'b1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic arm_trig(input int la, input int dc, output logic [DW-1:0] first);
        lastaddr = AW'(la);
        decim = CW'(dc);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("arm_busy", busy, 1);
        chk("arm_done_clr", done, 0);
        chk("arm_wc_clr", wordcount, 0);
        tick();
        tick();
        trig = 1'b1;
        first = adc + 1'b1;
        tick();
        trig = 1'b0;
        chk("trig_we0", bram_we, 0);
        tick();
        chk("lat_we0", bram_we, 0);
    endtask

    task automatic run_cap(input int n_total, input int n_run, input int sp, input int poke,
                           input logic [DW-1:0] first);
        logic [DW-1:0] ed;
        for (int i = 0; i < n_run; i++) begin
            if (i > 0) repeat (sp - 1) begin
                tick();
                chk("gap_we", bram_we, 0);
            end
            if (i == poke) begin
                start = 1'b1;
                lastaddr = 2;
            end
            tick();
            start = 1'b0;
            ed = first + DW'(i * sp);
            chk("wr_we", bram_we, 1);
            chk("wr_addr", bram_addr, i);
            chk("wr_data", bram_data, ed);
            chk("wr_wc", wordcount, i + 1);
            chk("wr_done", done, i == n_total - 1);
            chk("wr_busy", busy, i != n_total - 1);
        end
        if (n_run == n_total) repeat (3) begin
            tick();
            chk("post_we", bram_we, 0);
            chk("post_done", done, 1);
            chk("post_busy", busy, 0);
            chk("post_wc", wordcount, n_total);
        end
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_we", bram_we, 0);
        chk("rst_addr", bram_addr, 0);
        chk("rst_data", bram_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wc", wordcount, 0);
        reset = 1'b0;
        tick();

        arm_trig(7, 0, d0);
        run_cap(8, 8, 1, -1, d0);

        arm_trig(3, 2, d0);
        decim = 0;
        run_cap(4, 4, DSP, -1, d0);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        trig = 1'b1;
        repeat (5) begin
            tick();
            chk("idle_trig_we", bram_we, 0);
            chk("idle_trig_busy", busy, 0);
        end
        lastaddr = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("st_trig_busy", busy, 1);
        d0 = adc + 1'b1;
        tick();
        trig = 1'b0;
        chk("st_trig_we0", bram_we, 0);
        tick();
        chk("st_trig_we1", bram_we, 0);
        run_cap(2, 2, 1, -1, d0);

        arm_trig(15, 0, d0);
        run_cap(16, 16, 1, -1, d0);

        arm_trig(5, 0, d0);
        run_cap(6, 6, 1, 2, d0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rearm_done", done, 0);
        chk("rearm_wc", wordcount, 0);
        chk("rearm_busy", busy, 1);
        tick();
        trig = 1'b1;
        d0 = adc + 1'b1;
        tick();
        trig = 1'b0;
        tick();
        run_cap(3, 3, 1, -1, d0);

        arm_trig(15, 0, d0);
        run_cap(16, 5, 1, -1, d0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_we", bram_we, 0);
        chk("mid_rst_addr", bram_addr, 0);
        chk("mid_rst_data", bram_data, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_wc", wordcount, 0);
        arm_trig(3, 0, d0);
        run_cap(4, 4, 1, -1, d0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
